io_port_ctrl: RTL

Parametrised memory-mapped IO port between the MIPS core's data-bus decoder and board buttons, switches and LEDs. Adds button synchronisation, debouncing and edge detection. Switch snapshots taken on buttonR queue in a FIFO. CPU-written LED values are shown on buttonL.

---
 rtl/io_port_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/io_port_ctrl.sv
// Memory-mapped IO port: debounced buttons, switch-snapshot FIFO and LED register.
// Optional interrupt output is enabled by defining IOPORT_IRQ_EN.
module io_port_ctrl #(
    parameter int SW_W         = 16,
    parameter int LED_W        = 12,
    parameter int FIFO_DEPTH   = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int ADDR_W       = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pRead,
    input  logic              pWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       pWriteData,
    output logic [31:0]       pReadData,
    input  logic              buttonL,
    input  logic              buttonR,
    input  logic [SW_W-1:0]   switch,
    output logic [LED_W-1:0]  led
`ifdef IOPORT_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CYC) + 1;

    // index 0 = buttonL, index 1 = buttonR
    logic [1:0]            btn_s1_q, btn_s2_q, btn_deb_q, btn_deb_d;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [1:0]            press;
    logic [SW_W-1:0]       sw_s1_q, sw_s2_q;

    logic [SW_W-1:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  push_ok;

    logic [LED_W-1:0]      led_reg_q, led_reg_d;
    logic [LED_W-1:0]      led_q, led_d;
    logic                  led_shown_q, led_shown_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  rd_en, wr_en;
    logic                  pop_req, flush, clr_ovf;
    logic                  full, nonempty, pop_ok;
    logic [SW_W-1:0]       head;
    logic [31:0]           status;
    logic                  unused_wdata;

    assign unused_wdata = ^pWriteData;

    assign rd_en    = pRead;
    assign wr_en    = pWrite;
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign nonempty = (count_q != '0);
    assign head     = nonempty ? mem_q[rptr_q] : '0;
    assign pop_req  = rd_en && (addr == ADDR_W'(3));
    assign flush    = wr_en && (addr == ADDR_W'(4)) && pWriteData[1];
    assign clr_ovf  = wr_en && (addr == ADDR_W'(4)) && pWriteData[0];
    assign pop_ok   = pop_req && nonempty;

`ifdef IOPORT_IRQ_EN
    logic irq_on_data_q, irq_on_data_d;
    logic irq_on_ovf_q, irq_on_ovf_d;
    logic irq_q, irq_d;

    always_comb begin
        irq_on_data_d = irq_on_data_q;
        irq_on_ovf_d  = irq_on_ovf_q;
        if (wr_en && (addr == ADDR_W'(4))) begin
            irq_on_data_d = pWriteData[2];
            irq_on_ovf_d  = pWriteData[3];
        end
        irq_d = (irq_on_data_q & nonempty) | (irq_on_ovf_q & ovf_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_on_data_q <= 1'b0;
            irq_on_ovf_q  <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            irq_on_data_q <= irq_on_data_d;
            irq_on_ovf_q  <= irq_on_ovf_d;
            irq_q         <= irq_d;
        end
    end

    assign irq    = irq_q;
    assign status = {21'b0, irq_on_ovf_q, irq_on_data_q, 5'(count_q),
                     ovf_q, full, nonempty, led_shown_q};
`else
    assign status = {21'b0, 2'b00, 5'(count_q), ovf_q, full, nonempty, led_shown_q};
`endif

    // Debounce: counter runs only while the synchronised level disagrees with the accepted state.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            press[i]     = 1'b0;
            btn_deb_d[i] = btn_deb_q[i];
            db_cnt_d[i]  = db_cnt_q[i];
            if (btn_s2_q[i] == btn_deb_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                btn_deb_d[i] = ~btn_deb_q[i];
                db_cnt_d[i]  = '0;
                press[i]     = ~btn_deb_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
    end

    // FIFO: pop frees a slot in the same cycle, so a full FIFO accepts a concurrent push.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        push_ok = 1'b0;
        if (clr_ovf) ovf_d = 1'b0;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (press[1]) begin
                if (!full || pop_ok) push_ok = 1'b1;
                else                 ovf_d   = 1'b1;
            end
            if (push_ok) wptr_d = wptr_q + PTR_W'(1);
            if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
            if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
            else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
        end
    end

    // LED path: a CPU write in the same cycle as a show event still clears led_shown.
    always_comb begin
        led_reg_d   = led_reg_q;
        led_d       = led_q;
        led_shown_d = led_shown_q;
        if (press[0]) begin
            led_d       = led_reg_q;
            led_shown_d = 1'b1;
        end
        if (wr_en && (addr == ADDR_W'(1))) begin
            led_reg_d   = pWriteData[LED_W-1:0];
            led_shown_d = 1'b0;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (addr)
                ADDR_W'(0): rdata_d = status;
                ADDR_W'(1): rdata_d = 32'(led_reg_q);
                ADDR_W'(2): rdata_d = {24'b0, head[7:0]};
                ADDR_W'(3): rdata_d = 32'(head >> 8);
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_s1_q    <= '0;
            btn_s2_q    <= '0;
            btn_deb_q   <= '0;
            db_cnt_q    <= '0;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            led_reg_q   <= '0;
            led_q       <= '0;
            led_shown_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            btn_s1_q    <= {buttonR, buttonL};
            btn_s2_q    <= btn_s1_q;
            btn_deb_q   <= btn_deb_d;
            db_cnt_q    <= db_cnt_d;
            sw_s1_q     <= switch;
            sw_s2_q     <= sw_s1_q;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            led_reg_q   <= led_reg_d;
            led_q       <= led_d;
            led_shown_q <= led_shown_d;
            rdata_q     <= rdata_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= sw_s2_q;
    end

    assign led       = led_q;
    assign pReadData = rdata_q;

endmodule
